// File: rtl/cache_ctrl.sv
// cache_ctrl: sequencing controller for the cachek cache array.
// Handles single-word CPU read/write requests with compare accesses.
// A miss writes back a dirty victim line word by word, refills the
// line from memory and retries the compare. It also runs the array flush.
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   cpu_req/wr/addr/wdata       CPU request (sampled in IDLE only)
//   cpu_rdata, cpu_ready        read data and one-cycle completion pulse
//   flush_req, flush_done       flush request and one-cycle completion pulse
//   mem_req/wr/addr/wdata       memory request, held until mem_ack
//   mem_rdata, mem_ack          memory read data, single-cycle acknowledge
//   c_*  (out)                  cachek access controls, address and write data
//   c_*  (in)                   cachek hit/dirty/valid/ack, victim tag, read data
//
// Optional feature: define CACHE_CTRL_STATS_EN to add the saturating
// 16-bit hit_cnt / miss_cnt outputs.
module cache_ctrl #(
    parameter int TAG_W  = 5,
    parameter int IDX_W  = 4,
    parameter int WRD_W  = 2,
    parameter int DATA_W = 16,
    localparam int A_W   = TAG_W + IDX_W + WRD_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_wr,
    input  logic [A_W-1:0]    cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    input  logic              flush_req,
    output logic              flush_done,
    output logic              mem_req,
    output logic              mem_wr,
    output logic [A_W-1:0]    mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              c_enable,
    output logic              c_cmp,
    output logic              c_write,
    output logic              c_valid_in,
    output logic              c_rst,
    output logic [IDX_W-1:0]  c_index,
    output logic [WRD_W-1:0]  c_word,
    output logic [TAG_W-1:0]  c_tag,
    output logic [DATA_W-1:0] c_data_in,
    input  logic              c_hit,
    input  logic              c_dirty,
    input  logic              c_valid,
    input  logic              c_ack,
    input  logic [TAG_W-1:0]  c_tag_out,
    input  logic [DATA_W-1:0] c_data_out
`ifdef CACHE_CTRL_STATS_EN
    ,
    output logic [15:0]       hit_cnt,
    output logic [15:0]       miss_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE, S_COMPARE, S_WB_READ, S_WB_MEM,
        S_FILL_MEM, S_FILL_WR, S_DONE, S_FLUSH
    } state_t;

    localparam logic [WRD_W-1:0] K_LAST = '1;

    state_t              r_state, w_next;
    logic [WRD_W-1:0]    r_k;
    logic                r_wr;
    logic [TAG_W-1:0]    r_tag;
    logic [IDX_W-1:0]    r_idx;
    logic [WRD_W-1:0]    r_word;
    logic [DATA_W-1:0]   r_wdata;
    logic [TAG_W-1:0]    r_victim;
    // One buffer serves both the write-back word (WB_READ->WB_MEM) and
    // the fill word (FILL_MEM->FILL_WR); the two uses never overlap.
    logic [DATA_W-1:0]   r_buf;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_flush;  // DONE reports a flush, not a CPU op
    logic                r_retry;  // COMPARE is the post-fill retry
    logic [WRD_W-1:0]    w_k_inc;

    assign w_k_inc   = (r_k == K_LAST) ? '0 : r_k + 1'b1;
    assign cpu_rdata = r_rdata;

    // Outputs decode from state only, so they fall with the async reset.
    always_comb begin
        w_next     = r_state;
        cpu_ready  = 1'b0;
        flush_done = 1'b0;
        mem_req    = 1'b0;
        mem_wr     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        c_enable   = 1'b0;
        c_cmp      = 1'b0;
        c_write    = 1'b0;
        c_valid_in = 1'b0;
        c_rst      = 1'b0;
        c_index    = '0;
        c_word     = '0;
        c_tag      = '0;
        c_data_in  = '0;
        unique case (r_state)
            S_IDLE: begin
                if (flush_req)    w_next = S_FLUSH;
                else if (cpu_req) w_next = S_COMPARE;
            end
            S_COMPARE: begin
                c_enable  = 1'b1;
                c_cmp     = 1'b1;
                c_write   = r_wr;
                c_tag     = r_tag;
                c_index   = r_idx;
                c_word    = r_word;
                c_data_in = r_wdata;
                if (c_hit)                  w_next = S_DONE;
                else if (c_valid && c_dirty) w_next = S_WB_READ;
                else                        w_next = S_FILL_MEM;
            end
            S_WB_READ: begin
                c_enable = 1'b1;
                c_index  = r_idx;
                c_word   = r_k;
                w_next   = S_WB_MEM;
            end
            S_WB_MEM: begin
                mem_req   = 1'b1;
                mem_wr    = 1'b1;
                mem_addr  = {r_victim, r_idx, r_k};
                mem_wdata = r_buf;
                if (mem_ack) w_next = (r_k == K_LAST) ? S_FILL_MEM : S_WB_READ;
            end
            S_FILL_MEM: begin
                mem_req  = 1'b1;
                mem_addr = {r_tag, r_idx, r_k};
                if (mem_ack) w_next = S_FILL_WR;
            end
            S_FILL_WR: begin
                c_enable   = 1'b1;
                c_write    = 1'b1;
                c_valid_in = 1'b1;
                c_tag      = r_tag;
                c_index    = r_idx;
                c_word     = r_k;
                c_data_in  = r_buf;
                w_next     = (r_k == K_LAST) ? S_COMPARE : S_FILL_MEM;
            end
            S_DONE: begin
                cpu_ready  = ~r_flush;
                flush_done = r_flush;
                w_next     = S_IDLE;
            end
            S_FLUSH: begin
                c_enable = 1'b1;
                c_rst    = 1'b1;
                if (c_ack) w_next = S_DONE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_k      <= '0;
            r_wr     <= 1'b0;
            r_tag    <= '0;
            r_idx    <= '0;
            r_word   <= '0;
            r_wdata  <= '0;
            r_victim <= '0;
            r_buf    <= '0;
            r_rdata  <= '0;
            r_flush  <= 1'b0;
            r_retry  <= 1'b0;
        end else begin
            r_state <= w_next;
            unique case (r_state)
                S_IDLE: begin
                    if (flush_req) begin
                        r_flush <= 1'b1;
                    end else if (cpu_req) begin
                        r_flush <= 1'b0;
                        r_retry <= 1'b0;
                        r_wr    <= cpu_wr;
                        {r_tag, r_idx, r_word} <= cpu_addr;
                        r_wdata <= cpu_wdata;
                    end
                end
                S_COMPARE: begin
                    if (c_hit) begin
                        r_rdata <= c_data_out;
                    end else begin
                        r_k <= '0;
                        if (c_valid && c_dirty) r_victim <= c_tag_out;
                    end
                end
                S_WB_READ:  r_buf <= c_data_out;
                S_WB_MEM:   if (mem_ack) r_k <= w_k_inc;
                S_FILL_MEM: if (mem_ack) r_buf <= mem_rdata;
                S_FILL_WR: begin
                    r_k <= w_k_inc;
                    if (r_k == K_LAST) r_retry <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef CACHE_CTRL_STATS_EN
    logic [15:0] r_hit_cnt, r_miss_cnt;
    assign hit_cnt  = r_hit_cnt;
    assign miss_cnt = r_miss_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else if (r_state == S_IDLE && flush_req) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else if (r_state == S_COMPARE && !r_retry) begin
            if (c_hit) begin
                if (r_hit_cnt != '1) r_hit_cnt <= r_hit_cnt + 16'd1;
            end else begin
                if (r_miss_cnt != '1) r_miss_cnt <= r_miss_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cache_ctrl.sv
module tb_cache_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_req = 1'b0, cpu_wr = 1'b0, flush_req = 1'b0;
    logic [10:0] cpu_addr = '0;
    logic [15:0] cpu_wdata = '0;
    logic [15:0] cpu_rdata;
    logic        cpu_ready, flush_done;
    logic        mem_req, mem_wr, mem_ack;
    logic [10:0] mem_addr;
    logic [15:0] mem_wdata, mem_rdata;
    logic        c_enable, c_cmp, c_write, c_valid_in, c_rst;
    logic [3:0]  c_index;
    logic [1:0]  c_word;
    logic [4:0]  c_tag, c_tag_out;
    logic [15:0] c_data_in, c_data_out;
    logic        c_hit, c_dirty, c_valid, c_ack;
`ifdef CACHE_CTRL_STATS_EN
    logic [15:0] hit_cnt, miss_cnt;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cache_ctrl #(.TAG_W(5), .IDX_W(4), .WRD_W(2), .DATA_W(16)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
        .flush_req(flush_req), .flush_done(flush_done),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .c_enable(c_enable), .c_cmp(c_cmp), .c_write(c_write),
        .c_valid_in(c_valid_in), .c_rst(c_rst), .c_index(c_index),
        .c_word(c_word), .c_tag(c_tag), .c_data_in(c_data_in),
        .c_hit(c_hit), .c_dirty(c_dirty), .c_valid(c_valid), .c_ack(c_ack),
        .c_tag_out(c_tag_out), .c_data_out(c_data_out)
`ifdef CACHE_CTRL_STATS_EN
        , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
    );

    // ---------------- cachek model ----------------
    logic        model_init = 1'b1;
    logic [15:0] cm_data  [0:63];
    logic [4:0]  cm_tag   [0:15];
    logic        cm_valid [0:15];
    logic        cm_dirty [0:15];
    int          fl_cnt = 0;

    assign c_valid    = cm_valid[c_index];
    assign c_dirty    = cm_dirty[c_index];
    assign c_tag_out  = cm_tag[c_index];
    assign c_data_out = cm_data[{c_index, c_word}];
    assign c_hit      = c_enable && c_cmp && cm_valid[c_index] && (cm_tag[c_index] == c_tag);
    assign c_ack      = c_enable && c_rst && (fl_cnt == 3);

    always @(posedge clk) begin
        if (model_init) begin
            for (int i = 0; i < 16; i++) begin
                cm_valid[i] <= 1'b0;
                cm_dirty[i] <= 1'b0;
                cm_tag[i]   <= '0;
            end
            for (int i = 0; i < 64; i++) cm_data[i] <= '0;
            fl_cnt <= 0;
        end else begin
            if (c_enable && c_rst && !c_ack) fl_cnt <= fl_cnt + 1;
            else                             fl_cnt <= 0;
            if (c_enable && c_rst && c_ack)
                for (int i = 0; i < 16; i++) cm_valid[i] <= 1'b0;
            if (c_enable && !c_rst && c_cmp && c_write && c_hit) begin
                cm_data[{c_index, c_word}] <= c_data_in;
                cm_dirty[c_index] <= 1'b1;
            end
            if (c_enable && !c_rst && !c_cmp && c_write) begin
                cm_data[{c_index, c_word}] <= c_data_in;
                cm_tag[c_index]   <= c_tag;
                cm_valid[c_index] <= c_valid_in;
                cm_dirty[c_index] <= 1'b0;
            end
        end
    end

    // ---------------- memory model ----------------
    // Unwritten words read as 0x8000 | address.
    logic [15:0] mem     [0:2047];
    logic        mem_set [0:2047];
    int          m_delay = 0;
    int          m_cnt = 0;
    int          n_wr = 0, n_rd = 0;
    logic [10:0] wlog_a [0:63];
    logic [15:0] wlog_d [0:63];
    logic [10:0] rlog_a [0:63];

    assign mem_ack   = mem_req && (m_cnt == m_delay);
    assign mem_rdata = mem_set[mem_addr] ? mem[mem_addr] : (16'h8000 | {5'b0, mem_addr});

    always @(posedge clk) begin
        if (model_init) begin
            for (int i = 0; i < 2048; i++) mem_set[i] <= 1'b0;
            m_cnt <= 0;
        end else begin
            if (mem_req && !mem_ack) m_cnt <= m_cnt + 1;
            else                     m_cnt <= 0;
            if (mem_req && mem_ack) begin
                if (mem_wr) begin
                    mem[mem_addr]     <= mem_wdata;
                    mem_set[mem_addr] <= 1'b1;
                    wlog_a[n_wr[5:0]] <= mem_addr;
                    wlog_d[n_wr[5:0]] <= mem_wdata;
                    n_wr <= n_wr + 1;
                end else begin
                    rlog_a[n_rd[5:0]] <= mem_addr;
                    n_rd <= n_rd + 1;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // A held memory request must keep its address and data until acked.
    logic        pend = 1'b0;
    logic [10:0] pend_a;
    logic [15:0] pend_d;
    always @(negedge clk) begin
        if (mem_req && pend) begin
            check("mem_hold_addr", {21'b0, mem_addr}, {21'b0, pend_a});
            check("mem_hold_data", {16'b0, mem_wdata}, {16'b0, pend_d});
        end
        pend   = mem_req && !mem_ack;
        pend_a = mem_addr;
        pend_d = mem_wdata;
    end

    task automatic do_req(input logic wr, input logic [10:0] a, input logic [15:0] d,
                          output int lat, output logic [15:0] rd, output logic hit_seen);
        @(negedge clk);
        cpu_req = 1'b1; cpu_wr = wr; cpu_addr = a; cpu_wdata = d;
        @(posedge clk); #1;
        cpu_req = 1'b0;
        lat = 1;
        hit_seen = 1'b0;
        while (!cpu_ready && lat < 200) begin
            if (c_enable && c_cmp && c_hit) hit_seen = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        rd = cpu_rdata;
        if (!cpu_ready) lat = -1;
        @(posedge clk); #1;
        check("cpu_ready_pulse", {31'b0, cpu_ready}, 32'd0);
    endtask

    task automatic do_flush(output int rst_cyc, output int done_cyc);
        @(negedge clk);
        flush_req = 1'b1;
        @(posedge clk); #1;
        flush_req = 1'b0;
        done_cyc = 1;
        rst_cyc = 0;
        while (!flush_done && done_cyc < 100) begin
            if (c_rst) rst_cyc++;
            @(posedge clk); #1;
            done_cyc++;
        end
        if (!flush_done) done_cyc = -1;
        @(posedge clk); #1;
        check("flush_done_pulse", {31'b0, flush_done}, 32'd0);
    endtask

    initial begin
        int lat, rc, dc, wr0, rd0, k;
        logic [15:0] rd;
        logic hs;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        model_init = 1'b0;
        check("rst_cpu_ready", {31'b0, cpu_ready}, 32'd0);
        check("rst_mem_req",   {31'b0, mem_req},   32'd0);
        check("rst_c_enable",  {31'b0, c_enable},  32'd0);
        check("rst_c_rst",     {31'b0, c_rst},     32'd0);
        check("rst_rdata",     {16'b0, cpu_rdata}, 32'd0);
        check("rst_mem_addr",  {21'b0, mem_addr},  32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Clean write miss at {11101,0000,11} = 0x743
        wr0 = n_wr; rd0 = n_rd;
        do_req(1'b1, 11'h743, 16'h0F0F, lat, rd, hs);
        check("clean_miss_lat", lat, 32'd11);
        check("clean_miss_nrd", n_rd - rd0, 32'd4);
        check("clean_miss_nwr", n_wr - wr0, 32'd0);
        check("clean_miss_rd0", {21'b0, rlog_a[rd0]},     32'h740);
        check("clean_miss_rd3", {21'b0, rlog_a[rd0 + 3]}, 32'h743);
        check("fill_word0",     {16'b0, cm_data[0]},      32'h8740);
        check("write_word3",    {16'b0, cm_data[3]},      32'h0F0F);
        check("line_dirty",     {31'b0, cm_dirty[0]},     32'd1);

        // Read hit
        do_req(1'b0, 11'h743, 16'h0, lat, rd, hs);
        check("hit_lat",   lat, 32'd2);
        check("hit_rdata", {16'b0, rd}, 32'h0F0F);
        check("hit_seen",  {31'b0, hs}, 32'd1);

        // Dirty eviction: read {00010,0000,00} = 0x080
        wr0 = n_wr; rd0 = n_rd;
        do_req(1'b0, 11'h080, 16'h0, lat, rd, hs);
        check("dirty_lat",   lat, 32'd19);
        check("dirty_nwr",   n_wr - wr0, 32'd4);
        check("dirty_nrd",   n_rd - rd0, 32'd4);
        check("wb_addr0",    {21'b0, wlog_a[wr0]},     32'h740);
        check("wb_data0",    {16'b0, wlog_d[wr0]},     32'h8740);
        check("wb_addr3",    {21'b0, wlog_a[wr0 + 3]}, 32'h743);
        check("wb_data3",    {16'b0, wlog_d[wr0 + 3]}, 32'h0F0F);
        check("dirty_fill0", {21'b0, rlog_a[rd0]},     32'h080);
        check("dirty_rdata", {16'b0, rd}, 32'h8080);
        check("dirty_line_clean", {31'b0, cm_dirty[0]}, 32'd0);

        // Memory wait states: clean miss at {00011,0001,01} = 0x0C5
        m_delay = 3;
        do_req(1'b0, 11'h0C5, 16'h0, lat, rd, hs);
        check("wait_lat",   lat, 32'd23);
        check("wait_rdata", {16'b0, rd}, 32'h80C5);
        m_delay = 0;

`ifdef CACHE_CTRL_STATS_EN
        check("stats_hit_pre",  {16'b0, hit_cnt},  32'd1);
        check("stats_miss_pre", {16'b0, miss_cnt}, 32'd3);
`endif

        // Flush, then the prior address misses (clean, no write-back)
        do_flush(rc, dc);
        check("flush_crst_cycles", rc, 32'd4);
        check("flush_done_cycle",  dc, 32'd5);
        check("flush_invalid",     {31'b0, cm_valid[0]}, 32'd0);
`ifdef CACHE_CTRL_STATS_EN
        check("stats_hit_flush",  {16'b0, hit_cnt},  32'd0);
        check("stats_miss_flush", {16'b0, miss_cnt}, 32'd0);
`endif
        wr0 = n_wr;
        do_req(1'b0, 11'h080, 16'h0, lat, rd, hs);
        check("post_flush_lat",   lat, 32'd11);
        check("post_flush_nwr",   n_wr - wr0, 32'd0);
        check("post_flush_rdata", {16'b0, rd}, 32'h8080);
        do_req(1'b0, 11'h081, 16'h0, lat, rd, hs);
        check("hit2_rdata", {16'b0, rd}, 32'h8081);
        do_req(1'b0, 11'h082, 16'h0, lat, rd, hs);
        check("hit3_lat", lat, 32'd2);
`ifdef CACHE_CTRL_STATS_EN
        check("stats_hit_mhh",  {16'b0, hit_cnt},  32'd2);
        check("stats_miss_mhh", {16'b0, miss_cnt}, 32'd1);
        do_flush(rc, dc);
        check("stats_hit_clr",  {16'b0, hit_cnt},  32'd0);
        check("stats_miss_clr", {16'b0, miss_cnt}, 32'd0);
        do_req(1'b0, 11'h080, 16'h0, lat, rd, hs);
`endif

        // Make line 0 dirty, then reset during the write-back
        do_req(1'b1, 11'h080, 16'h1234, lat, rd, hs);
        check("dirty_write_lat", lat, 32'd2);
        m_delay = 5;
        wr0 = n_wr;
        @(negedge clk);
        cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 11'h1C0;
        @(posedge clk); #1;
        cpu_req = 1'b0;
        k = 0;
        while (!(mem_req && mem_wr) && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        check("reached_wb_mem", {31'b0, mem_req && mem_wr}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_mem_req",   {31'b0, mem_req},   32'd0);
        check("arst_mem_wr",    {31'b0, mem_wr},    32'd0);
        check("arst_c_enable",  {31'b0, c_enable},  32'd0);
        check("arst_mem_addr",  {21'b0, mem_addr},  32'd0);
        check("arst_mem_wdata", {16'b0, mem_wdata}, 32'd0);
        check("arst_cpu_ready", {31'b0, cpu_ready}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_delay = 0;
        k = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (mem_req) k++;
        end
        check("post_rst_no_mem_req", k, 32'd0);
        check("post_rst_no_wb",      n_wr - wr0, 32'd0);
        do_req(1'b0, 11'h080, 16'h0, lat, rd, hs);
        check("post_rst_hit_lat",   lat, 32'd2);
        check("post_rst_hit_rdata", {16'b0, rd}, 32'h1234);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/cache_ctrl.md
# cache_ctrl

Sequencing controller for the `cachek` cache array (16-bit words, 4-word lines, 5-bit tag, 4-bit index). It accepts single-word CPU read/write requests and drives `cachek` compare accesses. On a miss it writes back a dirty victim line word by word to main memory, then refills the line and retries the compare. It also runs the array's flush (`rst`/`ack`) sequence on request.

## Interface
- TAG_W, 5, tag width
- IDX_W, 4, index width
- WRD_W, 2, word-in-line width (line = 2^WRD_W words)
- DATA_W, 16, data width
- Address width A_W = TAG_W+IDX_W+WRD_W = 11; address layout {tag, index, word}, tag in MSBs.

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- cpu_req  in  1  request, sampled only in IDLE
- cpu_wr  in  1  1 = write, 0 = read
- cpu_addr  in  A_W  word address
- cpu_wdata  in  DATA_W  write data
- cpu_rdata  out  DATA_W  read data, valid while cpu_ready
- cpu_ready  out  1  one-cycle completion pulse
- flush_req  in  1  invalidate the whole array
- flush_done  out  1  one-cycle pulse
- mem_req, mem_wr  out  1 each  memory request / direction
- mem_addr  out  A_W; mem_wdata  out  DATA_W
- mem_rdata  in  DATA_W; mem_ack  in  1  single-cycle acknowledge
- c_enable, c_cmp, c_write, c_valid_in, c_rst  out  1 each  to cachek
- c_index  out  IDX_W; c_word  out  WRD_W; c_tag  out  TAG_W; c_data_in  out  DATA_W
- c_hit, c_dirty, c_valid, c_ack  in  1 each; c_tag_out  in  TAG_W; c_data_out  in  DATA_W

## Operation
- States: IDLE, COMPARE, WB_READ, WB_MEM, FILL_MEM, FILL_WR, DONE, FLUSH. Word counter k, WRD_W bits.
- IDLE:
  - flush_req → FLUSH. flush_req has priority over cpu_req.
  - Otherwise, cpu_req → latch addr/wdata/wr, go to COMPARE.
- COMPARE:
  - Drives c_enable=1, c_cmp=1, c_write=wr_q, tag/index/word/data from latched request.
  - c_hit → latch c_data_out, go to DONE. cachek performs the write on a write hit and sets dirty.
  - Miss with c_valid&c_dirty → latch c_tag_out as victim tag, k=0, go to WB_READ.
  - Any other miss → k=0, go to FILL_MEM.
- WB_READ: c_enable=1, c_cmp=0, c_write=0, c_word=k; latch c_data_out → WB_MEM.
- WB_MEM:
  - mem_req=1, mem_wr=1, mem_addr={victim tag, index, k}.
  - Hold until mem_ack.
  - On ack: k==3 → k=0, go to FILL_MEM; else k+1, go to WB_READ.
- FILL_MEM:
  - mem_req=1, mem_wr=0, mem_addr={req tag, index, k}.
  - On mem_ack latch mem_rdata → FILL_WR.
- FILL_WR:
  - c_enable=1, c_cmp=0, c_write=1, c_valid_in=1, c_word=k, c_data_in=fill data. This sets the tag, sets valid, clears dirty.
  - k==3 → COMPARE (retry, guaranteed hit); else k+1, go to FILL_MEM.
- DONE: cpu_ready=1, cpu_rdata held → IDLE.
- FLUSH:
  - c_enable=1, c_rst=1, held until c_ack sampled high.
  - Then flush_done=1 for one cycle → IDLE.
  - Dirty data is discarded, not written back.
- k wraps 3→0 only at the transitions listed above.

## Timing
- Reset:
  - All outputs 0; state IDLE; k=0; latched registers 0.
  - Reset mid-operation aborts immediately. mem_req and c_enable drop asynchronously. No partial write-back is completed.
- Cache outputs are used in the same cycle c_enable is asserted and are sampled at the closing edge.
- Latency counts from the accept edge (cpu_req sampled in IDLE) and assume mem_ack in the first cycle of each memory request:
  - Hit: cpu_ready in cycle 2.
  - Clean miss: cycle 11.
  - Dirty miss: cycle 19.
  - Each memory wait cycle adds 1.
- Memory handshake:
  - mem_req, mem_addr and mem_wdata are stable from assertion until mem_ack is sampled.
  - mem_req deasserts or advances on the next cycle.
  - mem_ack asserted without mem_req is ignored.
- CPU handshake:
  - Request fields are captured once.
  - The requester deasserts cpu_req in the cycle after cpu_ready.
  - cpu_req and flush_req outside IDLE are ignored, not queued.

## Configuration
- CACHE_CTRL_STATS_EN defined:
  - Adds outputs hit_cnt and miss_cnt, 16 bits each.
  - hit_cnt increments on a first-pass COMPARE hit.
  - miss_cnt increments on a first-pass miss.
  - The retry compare after a fill counts as neither.
  - Both counters saturate at 0xFFFF and clear on rst or on entering FLUSH.
- Undefined: no counters, no ports; behaviour otherwise identical.

## Test plan
- Write 0x0F0F to addr {11101,0000,11}:
  - Clean miss: 4 mem reads at word 0..3, 4 fill writes.
  - cpu_ready at cycle 11.
  - A following read returns 0x0F0F at cycle 2 with c_hit=1.
- Dirty eviction:
  - After the write above, read {00010,0000,00}.
  - 4 mem writes to {11101,0000,k}, word 3 data 0x0F0F, then 4 fills.
  - cpu_ready at cycle 19.
- Memory wait states: mem_ack delayed 3 cycles on every request → request held stable, miss latency 11+12=23.
- Flush:
  - flush_req with c_ack returned after 4 cycles → c_rst held 4 cycles, then flush_done pulse.
  - A subsequent read of the prior address misses.
- Reset asserted mid-WB_MEM → all outputs 0 asynchronously, IDLE after release, no further mem_req.
- With CACHE_CTRL_STATS_EN: sequence miss, hit, hit → hit_cnt=2, miss_cnt=1; flush clears both to 0.
